// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_pkg
//  Description : Opcodes, FSM state type and opcode classification helpers
//                shared by the LC3 memory-access stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IND  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    // LDR/STR take their address from the ALU (base+offset), the rest from the PC adder
    function automatic logic uses_base(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_lat_counter
//  Description : Wait counter for multi-cycle memory states; loads MEM_LAT-1
//                and counts down, 'last' flags the final cycle of the state.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_lat_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic last
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] c_load_val = CW'(MEM_LAT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign last = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lc3_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_access
//  Description : LC3 memory-access stage: LD/LDR/LDI/ST/STR/STI with indirect
//                pointer fetch. Optional device-region flag: LC3_MEM_ADDR_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_access
    import lc3_mem_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 16,
    parameter int          MEM_LAT  = 1,
    parameter logic [15:0] DEV_BASE = 16'hFE00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       IR_Exec,
    input  logic              Mem_Control_out,
    input  logic [15:0]       pcout,
    input  logic [15:0]       aluout,
    input  logic [15:0]       M_Data,
    input  logic [DATA_W-1:0] D_Dout,
    output logic [ADDR_W-1:0] D_Addr,
    output logic [DATA_W-1:0] D_Din,
    output logic              D_macc,
    output logic              D_rd,
    output logic [DATA_W-1:0] memout,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

`ifdef LC3_MEM_ADDR_CHECK_EN
    localparam logic c_chk_en = 1'b1;
`else
    localparam logic c_chk_en = 1'b0;
`endif

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_sdata;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_memout;
    logic              r_err;

    logic [3:0]        w_op;
    logic              w_accept;
    logic              w_last;
    logic              w_load_cnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [ADDR_W-1:0] w_ptr_addr;
    logic              w_unused;

    function automatic logic in_dev(input logic [ADDR_W-1:0] a);
        return 32'(a) >= 32'(DEV_BASE);
    endfunction

    assign w_op       = IR_Exec[15:12];
    assign w_unused   = &{1'b0, IR_Exec[11:0]};
    assign w_accept   = (r_state == IDLE) && start && (is_load(w_op) || is_store(w_op));
    assign w_sel_addr = uses_base(w_op) ? ADDR_W'(aluout) : ADDR_W'(pcout);
    assign w_ptr_addr = ADDR_W'(D_Dout);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (Mem_Control_out)      w_next = IND;
                    else if (is_load(w_op))   w_next = RD;
                    else                      w_next = WR;
                end
            end
            IND: begin
                if (w_last) w_next = is_load(r_op) ? RD : WR;
            end
            RD: begin
                if (w_last) w_next = DONE;
            end
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Every state change reloads the counter, so each timed state starts fresh
    assign w_load_cnt = (w_next != r_state);

    lc3_mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clock (clock),
        .reset (reset),
        .load  (w_load_cnt),
        .last  (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op     <= '0;
            r_addr   <= '0;
            r_sdata  <= '0;
            r_din    <= '0;
            r_memout <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_addr  <= w_sel_addr;
                r_sdata <= DATA_W'(M_Data);
                r_err   <= in_dev(w_sel_addr);
            end
            // Last indirection cycle: the fetched pointer becomes the access address
            if ((r_state == IND) && w_last) begin
                r_addr <= w_ptr_addr;
                r_err  <= r_err | in_dev(w_ptr_addr);
            end
            if (w_next == WR) begin
                r_din <= (r_state == IDLE) ? DATA_W'(M_Data) : r_sdata;
            end
            if ((r_state == RD) && w_last) begin
                r_memout <= D_Dout;
            end
        end
    end

    assign D_Addr   = r_addr;
    assign D_Din    = r_din;
    assign D_macc   = (r_state == IND) || (r_state == RD) || (r_state == WR);
    assign D_rd     = (r_state != WR);
    assign memout   = r_memout;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign addr_err = c_chk_en && (r_state == DONE) && r_err;

endmodule
`default_nettype wire
